// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// control_sequencer: hardwired fetch/decode/execute control unit for the System datapath.
// Build option MEM_WAIT_EN: F1, LD-T6 and ST-T7 stall until memory_done.   Rev 1.0
// ============================================================================
module control_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int STATE_W    = 6
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] IR_in,
    input  logic                  con_ff_bit,
    input  logic                  memory_done,
    input  logic                  Stop,
    output logic                  PCout,
    output logic                  MDRout,
    output logic                  Zlo_out,
    output logic                  Cout,
    output logic                  Rout,
    output logic                  Gra,
    output logic                  Grb,
    output logic                  Grc,
    output logic                  MARin,
    output logic                  MDRin,
    output logic                  IRin,
    output logic                  PCin,
    output logic                  Yin,
    output logic                  Zin,
    output logic                  Rin,
    output logic                  CONin,
    output logic                  IncPC,
    output logic                  Mem_Read,
    output logic                  Mem_Write,
    output logic                  Mem_enable512x32,
    output logic [4:0]            opcode,
    output logic                  Run,
    output logic                  illegal_op,
    output logic [STATE_W-1:0]    state_out
);
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ORI  = 5'b01010;
    localparam logic [4:0] OP_ANDI = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [STATE_W-1:0] {
        S_RESET, S_F0, S_F1, S_F2, S_DECODE, S_HALTED,
        S_ALU_T4, S_WB_T5, S_LDI_T4, S_IMM_T4,
        S_LD_T4, S_LD_T5, S_LD_T6, S_LD_T7,
        S_ST_T4, S_ST_T5, S_ST_T6, S_ST_T7,
        S_BR_T4, S_BR_T5, S_BR_T6
    } state_t;

    state_t     state_q, state_d, w_fin;
    logic [4:0] w_op;
    logic       w_mem_ok;
    logic       w_unused;

    assign w_op      = IR_in[DATA_WIDTH-1 -: 5];
    assign w_fin     = Stop ? S_HALTED : S_F0;
    assign state_out = state_q;

`ifdef MEM_WAIT_EN
    assign w_mem_ok = memory_done;
    assign w_unused = ^IR_in[DATA_WIDTH-6:0];
`else
    assign w_mem_ok = 1'b1;
    assign w_unused = ^{IR_in[DATA_WIDTH-6:0], memory_done};
`endif

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_F0;
            S_F0:     state_d = S_F1;
            S_F1:     if (w_mem_ok) state_d = S_F2;
            S_F2:     state_d = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_LD:                    state_d = S_LD_T4;
                    OP_ST:                    state_d = S_ST_T4;
                    OP_LDI:                   state_d = S_LDI_T4;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMM_T4;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_ALU_T4;
                    OP_BR:                    state_d = S_BR_T4;
                    OP_HALT:                  state_d = S_HALTED;
                    default:                  state_d = w_fin;  // NOP and unrecognised opcodes
                endcase
            end
            S_HALTED: state_d = S_HALTED;
            S_ALU_T4, S_LDI_T4, S_IMM_T4: state_d = S_WB_T5;
            S_WB_T5:  state_d = w_fin;
            S_LD_T4:  state_d = S_LD_T5;
            S_LD_T5:  state_d = S_LD_T6;
            S_LD_T6:  if (w_mem_ok) state_d = S_LD_T7;
            S_LD_T7:  state_d = w_fin;
            S_ST_T4:  state_d = S_ST_T5;
            S_ST_T5:  state_d = S_ST_T6;
            S_ST_T6:  state_d = S_ST_T7;
            S_ST_T7:  if (w_mem_ok) state_d = w_fin;
            S_BR_T4:  state_d = S_BR_T5;
            S_BR_T5:  state_d = S_BR_T6;
            S_BR_T6:  state_d = w_fin;
            default:  state_d = S_RESET;
        endcase
    end

    always_comb begin
        {PCout, MDRout, Zlo_out, Cout, Rout, Gra, Grb, Grc} = 8'b0;
        {MARin, MDRin, IRin, PCin, Yin, Zin, Rin, CONin}    = 8'b0;
        {IncPC, Mem_Read, Mem_Write, Mem_enable512x32}      = 4'b0;
        opcode     = 5'd0;
        illegal_op = 1'b0;
        Run        = (state_q != S_RESET) && (state_q != S_HALTED);
        case (state_q)
            S_F0:     begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_F1:     begin
                Zlo_out = 1'b1; PCin = 1'b1; Mem_Read = 1'b1;
                Mem_enable512x32 = 1'b1; MDRin = 1'b1;
            end
            S_F2:     begin MDRout = 1'b1; IRin = 1'b1; end
            // T3 strobes depend on the freshly loaded IR, so decode it directly here
            S_DECODE: begin
                case (w_op)
                    OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI,
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    OP_BR:            begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    OP_NOP, OP_HALT:  ;
                    default:          illegal_op = 1'b1;
                endcase
            end
            S_ALU_T4: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = w_op; end
            S_IMM_T4: begin Cout = 1'b1; Zin = 1'b1; opcode = w_op; end
            S_LDI_T4, S_LD_T4, S_ST_T4: begin Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD; end
            S_WB_T5:  begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            S_LD_T5, S_ST_T5: begin Zlo_out = 1'b1; MARin = 1'b1; end
            S_LD_T6:  begin Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; MDRin = 1'b1; end
            S_LD_T7:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            S_ST_T6:  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            S_ST_T7:  begin Mem_Write = 1'b1; Mem_enable512x32 = 1'b1; end
            S_BR_T4:  begin PCout = 1'b1; Yin = 1'b1; end
            S_BR_T5:  begin Cout = 1'b1; Zin = 1'b1; opcode = OP_ADD; end
            S_BR_T6:  begin Zlo_out = 1'b1; PCin = con_ff_bit; end
            default:  ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// tb_control_sequencer: directed instruction sequences with hand-derived strobe tables.
module tb_control_sequencer;
    localparam logic [19:0] PCOUT = 20'h80000, MDROUT = 20'h40000, ZLO   = 20'h20000, COUT  = 20'h10000;
    localparam logic [19:0] ROUT  = 20'h08000, GRA    = 20'h04000, GRB   = 20'h02000, GRC   = 20'h01000;
    localparam logic [19:0] MARIN = 20'h00800, MDRIN  = 20'h00400, IRIN  = 20'h00200, PCIN  = 20'h00100;
    localparam logic [19:0] YIN   = 20'h00080, ZIN    = 20'h00040, RIN   = 20'h00020, CONIN = 20'h00010;
    localparam logic [19:0] INCPC = 20'h00008, MRD    = 20'h00004, MWR   = 20'h00002, MEN   = 20'h00001;
    localparam logic [19:0] X_F0  = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [19:0] X_F1  = ZLO | PCIN | MRD | MEN | MDRIN;
    localparam logic [19:0] X_F2  = MDROUT | IRIN;
    localparam logic [19:0] X_T3  = GRB | ROUT | YIN;
    localparam logic [19:0] X_WB  = ZLO | GRA | RIN;
    localparam logic [5:0]  ST_RESET = 6'd0, ST_F0 = 6'd1, ST_HALTED = 6'd5;

    logic        Clock = 1'b0, clear = 1'b0, con_ff_bit = 1'b0, memory_done = 1'b0, Stop = 1'b0;
    logic [31:0] IR_in = 32'h0;
    logic PCout, MDRout, Zlo_out, Cout, Rout, Gra, Grb, Grc, MARin, MDRin, IRin, PCin;
    logic Yin, Zin, Rin, CONin, IncPC, Mem_Read, Mem_Write, Mem_enable512x32, Run, illegal_op;
    logic [4:0] opcode;
    logic [5:0] state_out;
    wire  [19:0] w_str = {PCout, MDRout, Zlo_out, Cout, Rout, Gra, Grb, Grc, MARin, MDRin,
                          IRin, PCin, Yin, Zin, Rin, CONin, IncPC, Mem_Read, Mem_Write, Mem_enable512x32};
    int n_checks = 0, n_fail = 0;

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .IR_in(IR_in), .con_ff_bit(con_ff_bit),
        .memory_done(memory_done), .Stop(Stop),
        .PCout(PCout), .MDRout(MDRout), .Zlo_out(Zlo_out), .Cout(Cout), .Rout(Rout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
        .PCin(PCin), .Yin(Yin), .Zin(Zin), .Rin(Rin), .CONin(CONin), .IncPC(IncPC),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_enable512x32(Mem_enable512x32),
        .opcode(opcode), .Run(Run), .illegal_op(illegal_op), .state_out(state_out)
    );

    always #5 Clock = ~Clock;

    task automatic do_reset();
        clear = 1'b0;
        Stop  = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        clear = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            n_checks++;
            if (w_str !== 20'h0 || opcode !== 5'd0 || Run !== 1'b0 || state_out !== ST_RESET) begin
                n_fail++;
                $display("FAIL reset cyc%0d: strobes=%h op=%b run=%b state=%0d, expected 0/0/0/%0d",
                         i, w_str, opcode, Run, state_out, ST_RESET);
            end
        end
        clear = 1'b1;
        @(negedge Clock);
        n_checks++;
        if (w_str !== X_F0 || state_out !== ST_F0 || Run !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: strobes=%h state=%0d run=%b, expected %h/%0d/1", w_str, state_out, Run, X_F0, ST_F0);
        end
    endtask

    task automatic test_ld();
        logic [19:0] es [8];
        es = '{X_F0, X_F1, X_F2, X_T3, COUT | ZIN, ZLO | MARIN, MRD | MEN | MDRIN, MDROUT | GRA | RIN};
        IR_in = 32'h0090_0001;  // LD r1,1(r2)
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (w_str !== es[i] || opcode !== ((i == 4) ? 5'b00011 : 5'b00000) || Run !== 1'b1 || illegal_op !== 1'b0) begin
                n_fail++;
                $display("FAIL ld step%0d: strobes=%h op=%b run=%b, expected strobes=%h op=%b run=1",
                         i, w_str, opcode, Run, es[i], (i == 4) ? 5'b00011 : 5'b00000);
            end
            @(negedge Clock);
        end
        n_checks++;
        if (w_str !== X_F0 || state_out !== ST_F0) begin
            n_fail++;
            $display("FAIL ld_done: strobes=%h state=%0d, expected %h/%0d", w_str, state_out, X_F0, ST_F0);
        end
    endtask

    task automatic test_andi();
        logic [19:0] es [6];
        es = '{X_F0, X_F1, X_F2, X_T3, COUT | ZIN, X_WB};
        IR_in = 32'h5880_0003;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (w_str !== es[i] || opcode !== ((i == 4) ? 5'b01011 : 5'b00000)) begin
                n_fail++;
                $display("FAIL andi step%0d: strobes=%h op=%b, expected strobes=%h op=%b",
                         i, w_str, opcode, es[i], (i == 4) ? 5'b01011 : 5'b00000);
            end
            @(negedge Clock);
        end
        n_checks++;
        if (w_str !== X_F0 || state_out !== ST_F0) begin
            n_fail++;
            $display("FAIL andi_done: strobes=%h state=%0d, expected %h/%0d", w_str, state_out, X_F0, ST_F0);
        end
    endtask

    task automatic test_sub();
        logic [19:0] es [6];
        es = '{X_F0, X_F1, X_F2, X_T3, GRC | ROUT | ZIN, X_WB};
        IR_in = 32'h2111_8000;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (w_str !== es[i] || opcode !== ((i == 4) ? 5'b00100 : 5'b00000)) begin
                n_fail++;
                $display("FAIL sub step%0d: strobes=%h op=%b, expected strobes=%h op=%b",
                         i, w_str, opcode, es[i], (i == 4) ? 5'b00100 : 5'b00000);
            end
            @(negedge Clock);
        end
        n_checks++;
        if (w_str !== X_F0) begin
            n_fail++;
            $display("FAIL sub_done: strobes=%h, expected %h", w_str, X_F0);
        end
    endtask

    task automatic test_st();
        logic [19:0] es [8];
        es = '{X_F0, X_F1, X_F2, X_T3, COUT | ZIN, ZLO | MARIN, GRA | ROUT | MDRIN, MWR | MEN};
        IR_in = 32'h1000_01F4;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (w_str !== es[i] || opcode !== ((i == 4) ? 5'b00011 : 5'b00000)) begin
                n_fail++;
                $display("FAIL st step%0d: strobes=%h op=%b, expected strobes=%h op=%b",
                         i, w_str, opcode, es[i], (i == 4) ? 5'b00011 : 5'b00000);
            end
            @(negedge Clock);
        end
        n_checks++;
        if (w_str !== X_F0) begin
            n_fail++;
            $display("FAIL st_done: strobes=%h, expected %h", w_str, X_F0);
        end
    endtask

    task automatic test_br(input logic con);
        logic [19:0] es [7];
        es = '{X_F0, X_F1, X_F2, GRA | ROUT | CONIN, PCOUT | YIN, COUT | ZIN, ZLO | (con ? PCIN : 20'h0)};
        IR_in      = 32'h9880_0010;
        con_ff_bit = con;
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (w_str !== es[i] || opcode !== ((i == 5) ? 5'b00011 : 5'b00000)) begin
                n_fail++;
                $display("FAIL br(con=%b) step%0d: strobes=%h op=%b, expected strobes=%h op=%b",
                         con, i, w_str, opcode, es[i], (i == 5) ? 5'b00011 : 5'b00000);
            end
            @(negedge Clock);
        end
        n_checks++;
        if (w_str !== X_F0) begin
            n_fail++;
            $display("FAIL br_done: strobes=%h, expected %h", w_str, X_F0);
        end
        con_ff_bit = 1'b0;
    endtask

    task automatic test_nop_illegal(input logic [31:0] ir, input logic ill);
        logic [19:0] es [4];
        es = '{X_F0, X_F1, X_F2, 20'h0};
        IR_in = ir;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (w_str !== es[i] || opcode !== 5'd0 || Run !== 1'b1 || illegal_op !== ((i == 3) ? ill : 1'b0)) begin
                n_fail++;
                $display("FAIL nop(ir=%h) step%0d: strobes=%h run=%b ill=%b, expected strobes=%h run=1 ill=%b",
                         ir, i, w_str, Run, illegal_op, es[i], (i == 3) ? ill : 1'b0);
            end
            @(negedge Clock);
        end
        n_checks++;
        if (w_str !== X_F0 || illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_done: strobes=%h ill=%b, expected %h/0", w_str, illegal_op, X_F0);
        end
    endtask

`ifdef MEM_WAIT_EN
    task automatic test_mem_wait();
        IR_in       = 32'hD000_0000;
        memory_done = 1'b0;
        @(negedge Clock);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (w_str !== X_F1) begin
                n_fail++;
                $display("FAIL mem_hold cyc%0d: strobes=%h, expected %h", i, w_str, X_F1);
            end
            if (i == 3) memory_done = 1'b1;
            @(negedge Clock);
        end
        n_checks++;
        if (w_str !== X_F2) begin
            n_fail++;
            $display("FAIL mem_release: strobes=%h, expected %h", w_str, X_F2);
        end
        @(negedge Clock);
        @(negedge Clock);
    endtask
`endif

    task automatic test_reset_mid_ld();
        IR_in = 32'h0090_0001;
        for (int i = 0; i < 6; i++) @(negedge Clock);
        n_checks++;
        if (w_str !== (MRD | MEN | MDRIN)) begin
            n_fail++;
            $display("FAIL rst_ld_t6: strobes=%h, expected %h", w_str, MRD | MEN | MDRIN);
        end
        clear = 1'b0;
        #1;
        n_checks++;
        if (w_str !== 20'h0 || opcode !== 5'd0 || Run !== 1'b0 || state_out !== ST_RESET) begin
            n_fail++;
            $display("FAIL rst_async: strobes=%h op=%b run=%b state=%0d, expected 0/0/0/%0d",
                     w_str, opcode, Run, state_out, ST_RESET);
        end
        @(negedge Clock);
        @(negedge Clock);
        clear = 1'b1;
        @(negedge Clock);
        n_checks++;
        if (w_str !== X_F0 || state_out !== ST_F0) begin
            n_fail++;
            $display("FAIL rst_ld_release: strobes=%h state=%0d, expected %h/%0d", w_str, state_out, X_F0, ST_F0);
        end
    endtask

    task automatic test_halt();
        IR_in = 32'hD800_0000;
        for (int i = 0; i < 4; i++) @(negedge Clock);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (w_str !== 20'h0 || Run !== 1'b0 || state_out !== ST_HALTED) begin
                n_fail++;
                $display("FAIL halt cyc%0d: strobes=%h run=%b state=%0d, expected 0/0/%0d", i, w_str, Run, state_out, ST_HALTED);
            end
            @(negedge Clock);
        end
        do_reset();
    endtask

    task automatic test_stop();
        logic [19:0] es [6];
        es = '{X_F0, X_F1, X_F2, X_T3, GRC | ROUT | ZIN, X_WB};
        IR_in = 32'h1880_0001;  // ADD: Stop raised from T3 must still let T4/T5 run
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (w_str !== es[i] || Run !== 1'b1) begin
                n_fail++;
                $display("FAIL stop step%0d: strobes=%h run=%b, expected strobes=%h run=1", i, w_str, Run, es[i]);
            end
            if (i == 3) Stop = 1'b1;
            @(negedge Clock);
        end
        n_checks++;
        if (w_str !== 20'h0 || opcode !== 5'd0 || Run !== 1'b0 || state_out !== ST_HALTED) begin
            n_fail++;
            $display("FAIL stop_halted: strobes=%h op=%b run=%b state=%0d, expected 0/0/0/%0d",
                     w_str, opcode, Run, state_out, ST_HALTED);
        end
        do_reset();
        n_checks++;
        if (w_str !== X_F0) begin
            n_fail++;
            $display("FAIL stop_recover: strobes=%h, expected %h", w_str, X_F0);
        end
    endtask

    initial begin
`ifdef MEM_WAIT_EN
        memory_done = 1'b1;
`endif
        test_reset();
        test_ld();
        test_andi();
        test_sub();
        test_st();
        test_br(1'b0);
        test_br(1'b1);
        test_nop_illegal(32'hD000_0000, 1'b0);
        test_nop_illegal(32'hF800_0000, 1'b1);
`ifdef MEM_WAIT_EN
        test_mem_wait();
`endif
        test_reset_mid_ld();
        test_halt();
        test_stop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
